// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers:
// the state encoding of the elastic skid stage and the default datapath width.
package cpu_pipe_pkg;

    localparam int unsigned PIPE_WIDTH = 32;

    // State encoding equals the number of words held, so occupancy is the state itself.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        PS_EMPTY = ST_EMPTY,
        PS_BUSY  = ST_BUSY,
        PS_FULL  = ST_FULL
    } pipe_state_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control path of the 2-entry skid stage: occupancy state machine plus the
// registered out_valid / in_ready flags, and the load/select strobes for the
// main and skid data registers held in the parent.
// Optional feature: PIPE_SKID_FLUSH_EN adds a synchronous, highest-priority flush input.
module pipe_skid_ctrl
    import cpu_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic       flush,
`endif
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output logic       load_main,
    output logic       sel_skid,
    output logic       load_skid
);

    pipe_state_e state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        acc, deq;

    // Handshakes use only registered flags, so nothing combinational crosses the stage.
    assign acc = in_valid & in_ready_q;
    assign deq = out_valid_q & out_ready;

    // Next-state and data-register strobes from the current occupancy and both handshakes.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_d   = state_q;
        load_main = 1'b0;
        sel_skid  = 1'b0;
        load_skid = 1'b0;
        unique case (state_q)
            PS_EMPTY: begin
                if (acc) begin
                    state_d   = PS_BUSY;
                    load_main = 1'b1;
                end
            end
            PS_BUSY: begin
                if (acc && !deq) begin
                    state_d   = PS_FULL;
                    load_skid = 1'b1;
                end else if (!acc && deq) begin
                    state_d   = PS_EMPTY;
                end else if (acc && deq) begin
                    load_main = 1'b1;
                end
            end
            PS_FULL: begin
                // in_ready is low here, so only a dequeue can happen.
                if (deq) begin
                    state_d   = PS_BUSY;
                    load_main = 1'b1;
                    sel_skid  = 1'b1;
                end
            end
            default: state_d = PS_EMPTY;
        endcase
`ifdef PIPE_SKID_FLUSH_EN
        // Flush wins over any transfer in the same cycle; data registers keep their contents.
        if (flush) begin
            state_d   = PS_EMPTY;
            load_main = 1'b0;
            sel_skid  = 1'b0;
            load_skid = 1'b0;
        end
`endif
    end

    // Flags are computed from the next state so they are valid right after the edge.
    always_comb begin
        out_valid_d = (state_d != PS_EMPTY);
        in_ready_d  = (state_d != PS_FULL);
    end

    // State and flag registers; reset empties the stage without waiting for a clock.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!clrn) begin
            state_q     <= PS_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign occupancy = state_q;

endmodule

// File: rtl/pipe_skid32.sv
// Elastic 2-entry pipeline register with valid/ready handshakes on both sides.
// out_data comes straight from the main register; the skid register absorbs one
// extra word while the downstream stage stalls, so in_ready can be registered.
// Optional feature: PIPE_SKID_FLUSH_EN adds the synchronous flush port.
module pipe_skid32
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned          WIDTH       = PIPE_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             clrn,
`ifdef PIPE_SKID_FLUSH_EN
    input  logic             flush,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             load_main, sel_skid, load_skid;

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .clrn      (clrn),
`ifdef PIPE_SKID_FLUSH_EN
        .flush     (flush),
`endif
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .occupancy (occupancy),
        .load_main (load_main),
        .sel_skid  (sel_skid),
        .load_skid (load_skid)
    );

    // Data register next values: main refills from the skid word or the input, skid from the input.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (load_main) begin
            main_d = sel_skid ? skid_q : in_data;
        end
        if (load_skid) begin
            skid_d = in_data;
        end
    end

    // Data registers; they keep their last word whenever no load strobe fires.
    always_ff @(posedge clk or negedge clrn) begin
        // NOTE: the data registers are reset deliberately so out_data shows RESET_VALUE after reset; without that requirement they could be left unreset.
        if (!clrn) begin
            main_q <= RESET_VALUE;
            skid_q <= RESET_VALUE;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign out_data = main_q;

endmodule
